// File: rtl/bsg_mem_2r1w_sync_rf_ctrl_if.sv
// Bus bundle between the register-file controller and its environment
// (write requesters, read ports, and the 2R1W synchronous RAM).
//   w0_*/w1_*      : write requesters (valid/addr/data in, ready out)
//   r0_*/r1_*      : operand read ports (request in, valid/data out one cycle later)
//   mem_w_*        : RAM write port (driven by the controller)
//   mem_r0_*/r1_*  : RAM read ports (enable/addr out, sync data in)
//   init_done_o    : controller has finished the post-reset clear sweep
// Modports: slave = controller view, master = environment view.
interface bsg_mem_2r1w_sync_rf_ctrl_if #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 64
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic                     w0_v_i;
    logic [addr_width_lp-1:0] w0_addr_i;
    logic [width_p-1:0]       w0_data_i;
    logic                     w0_ready_o;
    logic                     w1_v_i;
    logic [addr_width_lp-1:0] w1_addr_i;
    logic [width_p-1:0]       w1_data_i;
    logic                     w1_ready_o;

    logic                     r0_v_i;
    logic [addr_width_lp-1:0] r0_addr_i;
    logic                     r0_v_o;
    logic [width_p-1:0]       r0_data_o;
    logic                     r1_v_i;
    logic [addr_width_lp-1:0] r1_addr_i;
    logic                     r1_v_o;
    logic [width_p-1:0]       r1_data_o;

    logic                     mem_w_v_o;
    logic [addr_width_lp-1:0] mem_w_addr_o;
    logic [width_p-1:0]       mem_w_data_o;
    logic                     mem_r0_v_o;
    logic [addr_width_lp-1:0] mem_r0_addr_o;
    logic [width_p-1:0]       mem_r0_data_i;
    logic                     mem_r1_v_o;
    logic [addr_width_lp-1:0] mem_r1_addr_o;
    logic [width_p-1:0]       mem_r1_data_i;

    logic                     init_done_o;

    modport slave (
        input  w0_v_i, w0_addr_i, w0_data_i, w1_v_i, w1_addr_i, w1_data_i,
        input  r0_v_i, r0_addr_i, r1_v_i, r1_addr_i,
        input  mem_r0_data_i, mem_r1_data_i,
        output w0_ready_o, w1_ready_o, r0_v_o, r0_data_o, r1_v_o, r1_data_o,
        output mem_w_v_o, mem_w_addr_o, mem_w_data_o,
        output mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o,
        output init_done_o
    );

    modport master (
        output w0_v_i, w0_addr_i, w0_data_i, w1_v_i, w1_addr_i, w1_data_i,
        output r0_v_i, r0_addr_i, r1_v_i, r1_addr_i,
        output mem_r0_data_i, mem_r1_data_i,
        input  w0_ready_o, w1_ready_o, r0_v_o, r0_data_o, r1_v_o, r1_data_o,
        input  mem_w_v_o, mem_w_addr_o, mem_w_data_o,
        input  mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o,
        input  init_done_o
    );
endinterface

// File: rtl/bsg_mem_2r1w_sync_rf_ctrl.sv
// Front-end controller for a 2R1W synchronous register file RAM that does not
// support same-address read/write in one cycle. Clears the array after reset,
// round-robins two write requesters onto the single write port, and turns
// read/write address collisions into a one-cycle write-data forward.
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   bus        : requester, read-port and RAM-side signals (slave modport)
module bsg_mem_2r1w_sync_rf_ctrl #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned els_p       = 64,
    parameter bit          zero_init_p = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bsg_mem_2r1w_sync_rf_ctrl_if.slave  bus
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                   r_state, w_state_nxt;
    logic [addr_width_lp-1:0] r_cnt, w_cnt_nxt;
    logic                     r_rr, w_rr_nxt;       // 0: requester 0 favoured
    logic                     r_r0_v, r_r1_v;
    logic                     r_byp0, r_byp1;
    logic [width_p-1:0]       r_byp_data0, r_byp_data1;
    logic                     r_init_done;

    logic                     w_run;
    logic                     w_grant0, w_grant1;
    logic                     w_mem_w_v;
    logic [addr_width_lp-1:0] w_mem_w_addr;
    logic [width_p-1:0]       w_mem_w_data;
    logic                     w_hit0, w_hit1;
    logic                     w_mem_r0_v, w_mem_r1_v;

    // State, sweep counter, arbiter pointer and read-return pipeline
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= zero_init_p ? S_INIT : S_RUN;
            r_cnt       <= '0;
            r_rr        <= 1'b0;
            r_r0_v      <= 1'b0;
            r_r1_v      <= 1'b0;
            r_byp0      <= 1'b0;
            r_byp1      <= 1'b0;
            r_byp_data0 <= '0;
            r_byp_data1 <= '0;
            r_init_done <= ~zero_init_p;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr        <= w_rr_nxt;
            r_r0_v      <= w_run & bus.r0_v_i;
            r_r1_v      <= w_run & bus.r1_v_i;
            r_byp0      <= w_hit0;
            r_byp1      <= w_hit1;
            if (w_hit0) r_byp_data0 <= w_mem_w_data;
            if (w_hit1) r_byp_data1 <= w_mem_w_data;
            r_init_done <= (w_state_nxt == S_RUN);
        end
    end

    // Next state, write arbitration and collision detection; gated by reset so
    // nothing reaches the RAM while reset is held
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rr_nxt     = r_rr;
        w_run        = 1'b0;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_mem_w_v    = 1'b0;
        w_mem_w_addr = '0;
        w_mem_w_data = '0;
        w_hit0       = 1'b0;
        w_hit1       = 1'b0;
        w_mem_r0_v   = 1'b0;
        w_mem_r1_v   = 1'b0;
        if (reset_n_i) begin
            unique case (r_state)
                S_INIT: begin
                    w_mem_w_v    = 1'b1;
                    w_mem_w_addr = r_cnt;
                    w_cnt_nxt    = r_cnt + addr_width_lp'(1);
                    if (r_cnt == last_addr_lp) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    w_run        = 1'b1;
                    w_grant0     = bus.w0_v_i & (~bus.w1_v_i | ~r_rr);
                    w_grant1     = bus.w1_v_i & (~bus.w0_v_i |  r_rr);
                    w_mem_w_v    = bus.w0_v_i | bus.w1_v_i;
                    w_mem_w_addr = w_grant1 ? bus.w1_addr_i : bus.w0_addr_i;
                    w_mem_w_data = w_grant1 ? bus.w1_data_i : bus.w0_data_i;
                    // Pointer always lands on the requester that was not served
                    if (w_mem_w_v) w_rr_nxt = w_grant0;
                    w_hit0       = bus.r0_v_i & w_mem_w_v & (bus.r0_addr_i == w_mem_w_addr);
                    w_hit1       = bus.r1_v_i & w_mem_w_v & (bus.r1_addr_i == w_mem_w_addr);
                    w_mem_r0_v   = bus.r0_v_i & ~w_hit0;
                    w_mem_r1_v   = bus.r1_v_i & ~w_hit1;
                end
                default: ;
            endcase
        end
    end

    assign bus.w0_ready_o    = w_grant0;
    assign bus.w1_ready_o    = w_grant1;
    assign bus.mem_w_v_o     = w_mem_w_v;
    assign bus.mem_w_addr_o  = w_mem_w_addr;
    assign bus.mem_w_data_o  = w_mem_w_data;
    assign bus.mem_r0_v_o    = w_mem_r0_v;
    assign bus.mem_r0_addr_o = bus.r0_addr_i;
    assign bus.mem_r1_v_o    = w_mem_r1_v;
    assign bus.mem_r1_addr_o = bus.r1_addr_i;
    assign bus.r0_v_o        = r_r0_v;
    assign bus.r1_v_o        = r_r1_v;
    // Forwarded write data replaces the suppressed RAM read
    assign bus.r0_data_o     = r_byp0 ? r_byp_data0 : bus.mem_r0_data_i;
    assign bus.r1_data_o     = r_byp1 ? r_byp_data1 : bus.mem_r1_data_i;
    assign bus.init_done_o   = r_init_done;
endmodule

// File: tb/tb_bsg_mem_2r1w_sync_rf_ctrl.sv
// Scoreboard bench: DUT A (zero_init_p=1) and DUT B (zero_init_p=0), each with
// a behavioural 2R1W synchronous RAM.
module tb_bsg_mem_2r1w_sync_rf_ctrl;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned ELS   = 64;
    localparam int unsigned AW    = 6;

    localparam int ID_DONE = 0, ID_RDY0 = 1, ID_RDY1 = 2, ID_MWV = 3, ID_MR0V = 4,
                   ID_MR1V = 5, ID_R0V = 6, ID_R1V = 7, ID_B_DONE = 8, ID_B_RDY1 = 9,
                   ID_B_MWV = 10, ID_B_MWA = 11, ID_B_MR0V = 12, ID_B_MR1V = 13;

    typedef struct { int cyc; int id; logic [31:0] exp; } tchk_t;
    typedef struct { logic [AW-1:0] addr; logic [WIDTH-1:0] data; logic g0; logic g1; } wexp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic seed;
    int   n_cmp, n_err, n, cyc;

    tchk_t            tq[$];
    wexp_t            wq[$];
    logic [WIDTH-1:0] r0q[$], r1q[$], br0q[$], br1q[$];

    always #5 clk = ~clk;

    bsg_mem_2r1w_sync_rf_ctrl_if #(.width_p(WIDTH), .els_p(ELS)) bus_a ();
    bsg_mem_2r1w_sync_rf_ctrl_if #(.width_p(WIDTH), .els_p(ELS)) bus_b ();

    bsg_mem_2r1w_sync_rf_ctrl #(.width_p(WIDTH), .els_p(ELS), .zero_init_p(1'b1)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus_a));
    bsg_mem_2r1w_sync_rf_ctrl #(.width_p(WIDTH), .els_p(ELS), .zero_init_p(1'b0)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus_b));

    // Behavioural RAMs, pre-filled with non-zero patterns
    logic [WIDTH-1:0] ram_a [ELS];
    logic [WIDTH-1:0] ram_b [ELS];
    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < int'(ELS); i++) begin
                ram_a[i] <= 32'hBAD0_0000 | WIDTH'(i);
                ram_b[i] <= 32'hB000_0000 | WIDTH'(i);
            end
        end else begin
            if (bus_a.mem_w_v_o)  ram_a[bus_a.mem_w_addr_o] <= bus_a.mem_w_data_o;
            if (bus_a.mem_r0_v_o) bus_a.mem_r0_data_i <= ram_a[bus_a.mem_r0_addr_o];
            if (bus_a.mem_r1_v_o) bus_a.mem_r1_data_i <= ram_a[bus_a.mem_r1_addr_o];
            if (bus_b.mem_w_v_o)  ram_b[bus_b.mem_w_addr_o] <= bus_b.mem_w_data_o;
            if (bus_b.mem_r0_v_o) bus_b.mem_r0_data_i <= ram_b[bus_b.mem_r0_addr_o];
            if (bus_b.mem_r1_v_o) bus_b.mem_r1_data_i <= ram_b[bus_b.mem_r1_addr_o];
        end
    end

    function automatic string id_name(input int id);
        case (id)
            ID_DONE:   return "a_init_done";
            ID_RDY0:   return "a_w0_ready";
            ID_RDY1:   return "a_w1_ready";
            ID_MWV:    return "a_mem_w_v";
            ID_MR0V:   return "a_mem_r0_v";
            ID_MR1V:   return "a_mem_r1_v";
            ID_R0V:    return "a_r0_v";
            ID_R1V:    return "a_r1_v";
            ID_B_DONE: return "b_init_done";
            ID_B_RDY1: return "b_w1_ready";
            ID_B_MWV:  return "b_mem_w_v";
            ID_B_MWA:  return "b_mem_w_addr";
            ID_B_MR0V: return "b_mem_r0_v";
            ID_B_MR1V: return "b_mem_r1_v";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] sig(input int id);
        case (id)
            ID_DONE:   return 32'(bus_a.init_done_o);
            ID_RDY0:   return 32'(bus_a.w0_ready_o);
            ID_RDY1:   return 32'(bus_a.w1_ready_o);
            ID_MWV:    return 32'(bus_a.mem_w_v_o);
            ID_MR0V:   return 32'(bus_a.mem_r0_v_o);
            ID_MR1V:   return 32'(bus_a.mem_r1_v_o);
            ID_R0V:    return 32'(bus_a.r0_v_o);
            ID_R1V:    return 32'(bus_a.r1_v_o);
            ID_B_DONE: return 32'(bus_b.init_done_o);
            ID_B_RDY1: return 32'(bus_b.w1_ready_o);
            ID_B_MWV:  return 32'(bus_b.mem_w_v_o);
            ID_B_MWA:  return 32'(bus_b.mem_w_addr_o);
            ID_B_MR0V: return 32'(bus_b.mem_r0_v_o);
            ID_B_MR1V: return 32'(bus_b.mem_r1_v_o);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic pop_read(input string nm, inout logic [WIDTH-1:0] q[$], input logic [WIDTH-1:0] act);
        if (q.size() == 0) chk({nm, "_unexpected_valid"}, 64'd1, 64'd0);
        else chk(nm, 64'(act), 64'(q.pop_front()));
    endtask

    // Monitor: tagged control checks plus output-triggered scoreboard pops
    task automatic monitor();
        wexp_t w;
        forever begin
            @(negedge clk);
            n++;
            for (int k = tq.size() - 1; k >= 0; k--) begin
                if (tq[k].cyc <= n) begin
                    chk(id_name(tq[k].id), 64'(sig(tq[k].id)), 64'(tq[k].exp));
                    tq.delete(k);
                end
            end
            if (bus_a.mem_w_v_o) begin
                if (wq.size() == 0) chk("a_wport_unexpected", 64'd1, 64'd0);
                else begin
                    w = wq.pop_front();
                    chk("a_wport", 64'({bus_a.w1_ready_o, bus_a.w0_ready_o, bus_a.mem_w_addr_o, bus_a.mem_w_data_o}),
                        64'({w.g1, w.g0, w.addr, w.data}));
                end
                if (bus_a.mem_r0_v_o) chk("a_r0_collision", 64'(bus_a.mem_r0_addr_o == bus_a.mem_w_addr_o), 64'd0);
                if (bus_a.mem_r1_v_o) chk("a_r1_collision", 64'(bus_a.mem_r1_addr_o == bus_a.mem_w_addr_o), 64'd0);
            end
            if (bus_a.r0_v_o) pop_read("a_r0_data", r0q, bus_a.r0_data_o);
            if (bus_a.r1_v_o) pop_read("a_r1_data", r1q, bus_a.r1_data_o);
            if (bus_b.r0_v_o) pop_read("b_r0_data", br0q, bus_b.r0_data_o);
            if (bus_b.r1_v_o) pop_read("b_r1_data", br1q, bus_b.r1_data_o);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = n + 1;
    endtask

    task automatic expect_t(input int c, input int id, input logic [31:0] e);
        tchk_t t;
        t.cyc = c; t.id = id; t.exp = e;
        tq.push_back(t);
    endtask

    task automatic expect_w(input int a, input logic [WIDTH-1:0] d, input logic g0, input logic g1);
        wexp_t w;
        w.addr = AW'(a); w.data = d; w.g0 = g0; w.g1 = g1;
        wq.push_back(w);
    endtask

    task automatic idle_a();
        bus_a.w0_v_i = 1'b0; bus_a.w0_addr_i = '0; bus_a.w0_data_i = '0;
        bus_a.w1_v_i = 1'b0; bus_a.w1_addr_i = '0; bus_a.w1_data_i = '0;
        bus_a.r0_v_i = 1'b0; bus_a.r0_addr_i = '0;
        bus_a.r1_v_i = 1'b0; bus_a.r1_addr_i = '0;
    endtask

    task automatic idle_b();
        bus_b.w0_v_i = 1'b0; bus_b.w0_addr_i = '0; bus_b.w0_data_i = '0;
        bus_b.w1_v_i = 1'b0; bus_b.w1_addr_i = '0; bus_b.w1_data_i = '0;
        bus_b.r0_v_i = 1'b0; bus_b.r0_addr_i = '0;
        bus_b.r1_v_i = 1'b0; bus_b.r1_addr_i = '0;
    endtask

    task automatic wr_a(input logic v0, input int a0, input logic [WIDTH-1:0] d0,
                        input logic v1, input int a1, input logic [WIDTH-1:0] d1);
        bus_a.w0_v_i = v0; bus_a.w0_addr_i = AW'(a0); bus_a.w0_data_i = d0;
        bus_a.w1_v_i = v1; bus_a.w1_addr_i = AW'(a1); bus_a.w1_data_i = d1;
    endtask

    task automatic rd_a(input logic v0, input int a0, input logic v1, input int a1);
        bus_a.r0_v_i = v0; bus_a.r0_addr_i = AW'(a0);
        bus_a.r1_v_i = v1; bus_a.r1_addr_i = AW'(a1);
    endtask

    initial begin
        int c0, c1, c2, r;
        n_cmp = 0; n_err = 0; n = 0; cyc = 0;
        rst_n = 1'b0; seed = 1'b1;
        idle_a(); idle_b();
        bus_a.mem_r0_data_i = '0; bus_a.mem_r1_data_i = '0;
        bus_b.mem_r0_data_i = '0; bus_b.mem_r1_data_i = '0;
        fork
            monitor();
        join_none

        // Reset values
        tick();
        expect_t(cyc, ID_DONE, 0); expect_t(cyc, ID_MWV, 0); expect_t(cyc, ID_R0V, 0);
        expect_t(cyc, ID_R1V, 0); expect_t(cyc, ID_RDY0, 0); expect_t(cyc, ID_B_DONE, 1);
        tick();
        seed = 1'b0;

        // Release: A sweeps 0..63; B is immediately in RUN
        tick();
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < int'(ELS); i++) expect_w(i, '0, 1'b0, 1'b0);
        expect_t(c0 + 63, ID_DONE, 0);
        expect_t(c0 + 64, ID_DONE, 1);
        bus_b.w1_v_i = 1'b1; bus_b.w1_addr_i = AW'(2); bus_b.w1_data_i = 32'hAB;
        bus_b.r0_v_i = 1'b1; bus_b.r0_addr_i = AW'(2);
        bus_b.r1_v_i = 1'b1; bus_b.r1_addr_i = AW'(5);
        expect_t(c0, ID_B_DONE, 1); expect_t(c0, ID_B_RDY1, 1); expect_t(c0, ID_B_MWV, 1);
        expect_t(c0, ID_B_MWA, 2); expect_t(c0, ID_B_MR0V, 0); expect_t(c0, ID_B_MR1V, 1);
        br0q.push_back(32'hAB);
        br1q.push_back(32'hB000_0005);

        tick();
        idle_b();
        bus_b.r0_v_i = 1'b1; bus_b.r0_addr_i = AW'(2);
        expect_t(cyc, ID_B_MR0V, 1);
        br0q.push_back(32'hAB);

        // Requests during INIT are dropped
        tick();
        idle_b();
        rd_a(1'b1, 5, 1'b0, 0);
        wr_a(1'b1, 9, 32'h99, 1'b0, 0, '0);
        expect_t(cyc, ID_RDY0, 0); expect_t(cyc, ID_MR0V, 0); expect_t(cyc + 1, ID_R0V, 0);
        tick();
        idle_a();
        while (cyc < c0 + 65) tick();

        // First RUN read: cleared entry
        r = cyc;
        rd_a(1'b1, 5, 1'b0, 0);
        expect_t(r, ID_MR0V, 1);
        r0q.push_back('0);

        // Round-robin with both requesters valid
        for (int k = 0; k < 4; k++) begin
            tick(); idle_a();
            wr_a(1'b1, 10 + k, 32'h100 + WIDTH'(k), 1'b1, 20 + k, 32'h200 + WIDTH'(k));
            if (k % 2 == 0) expect_w(10 + k, 32'h100 + WIDTH'(k), 1'b1, 1'b0);
            else            expect_w(20 + k, 32'h200 + WIDTH'(k), 1'b0, 1'b1);
        end
        tick(); wr_a(1'b0, 0, '0, 1'b1, 30, 32'h300);       expect_w(30, 32'h300, 1'b0, 1'b1);
        tick(); wr_a(1'b1, 33, 32'h333, 1'b0, 0, '0);       expect_w(33, 32'h333, 1'b1, 1'b0);
        tick(); wr_a(1'b1, 34, 32'h334, 1'b1, 35, 32'h335); expect_w(35, 32'h335, 1'b0, 1'b1);
        tick(); wr_a(1'b0, 0, '0, 1'b1, 36, 32'h336);       expect_w(36, 32'h336, 1'b0, 1'b1);
        tick(); wr_a(1'b1, 37, 32'h337, 1'b1, 38, 32'h338); expect_w(37, 32'h337, 1'b1, 1'b0);

        // Both read ports collide with the write: forwarded
        tick(); idle_a();
        wr_a(1'b1, 7, 32'hDEAD_BEEF, 1'b0, 0, '0); rd_a(1'b1, 7, 1'b1, 7);
        expect_w(7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        expect_t(cyc, ID_MR0V, 0); expect_t(cyc, ID_MR1V, 0);
        expect_t(cyc + 1, ID_R0V, 1); expect_t(cyc + 1, ID_R1V, 1);
        r0q.push_back(32'hDEAD_BEEF); r1q.push_back(32'hDEAD_BEEF);

        // Plain reads from the RAM; bypass must not stick
        tick(); idle_a();
        rd_a(1'b1, 7, 1'b1, 10);
        expect_t(cyc, ID_MR0V, 1); expect_t(cyc, ID_MR1V, 1);
        r0q.push_back(32'hDEAD_BEEF); r1q.push_back(32'h100);

        tick(); idle_a();
        wr_a(1'b1, 3, 32'h11, 1'b0, 0, '0);
        expect_w(3, 32'h11, 1'b1, 1'b0);

        tick(); idle_a();
        wr_a(1'b0, 0, '0, 1'b1, 4, 32'h44); rd_a(1'b1, 4, 1'b1, 3);
        expect_w(4, 32'h44, 1'b0, 1'b1);
        expect_t(cyc, ID_MR1V, 1); expect_t(cyc, ID_MR0V, 0);
        r0q.push_back(32'h44); r1q.push_back(32'h11);

        tick(); idle_a();
        rd_a(1'b1, 63, 1'b1, 4);
        r0q.push_back('0); r1q.push_back(32'h44);

        // One port hits, the other reads the RAM
        tick(); idle_a();
        wr_a(1'b0, 0, '0, 1'b1, 8, 32'h88); rd_a(1'b1, 8, 1'b1, 9);
        expect_w(8, 32'h88, 1'b0, 1'b1);
        expect_t(cyc, ID_MR0V, 0); expect_t(cyc, ID_MR1V, 1);
        r0q.push_back(32'h88); r1q.push_back('0);

        tick(); idle_a();
        tick();
        rd_a(1'b1, 3, 1'b0, 0);

        // Async reset kills the read return already in flight
        tick(); idle_a();
        rst_n = 1'b0;
        expect_t(cyc, ID_R0V, 0); expect_t(cyc, ID_DONE, 0); expect_t(cyc, ID_MWV, 0);

        tick();
        rst_n = 1'b1;
        c1 = cyc;
        for (int i = 0; i < 20; i++) expect_w(i, '0, 1'b0, 1'b0);
        while (cyc < c1 + 19) tick();

        // Reset pulse in the middle of the sweep
        tick();
        rst_n = 1'b0;
        expect_t(cyc, ID_MWV, 0); expect_t(cyc, ID_DONE, 0);

        tick();
        rst_n = 1'b1;
        c2 = cyc;
        for (int i = 0; i < int'(ELS); i++) expect_w(i, '0, 1'b0, 1'b0);
        expect_t(c2 + 63, ID_DONE, 0);
        expect_t(c2 + 64, ID_DONE, 1);
        while (cyc < c2 + 65) tick();

        // Sweep cleared previously written entries
        rd_a(1'b1, 7, 1'b1, 19);
        r0q.push_back('0); r1q.push_back('0);
        tick(); idle_a();
        repeat (3) tick();

        chk("a_wq_drained",   64'(wq.size()),   64'd0);
        chk("a_r0q_drained",  64'(r0q.size()),  64'd0);
        chk("a_r1q_drained",  64'(r1q.size()),  64'd0);
        chk("b_r0q_drained",  64'(br0q.size()), 64'd0);
        chk("b_r1q_drained",  64'(br1q.size()), 64'd0);
        chk("tagged_drained", 64'(tq.size()),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bsg_mem_2r1w_sync_rf_ctrl.md
Name: bsg_mem_2r1w_sync_rf_ctrl

Overview:
Front-end controller for a 2-read/1-write synchronous register-file RAM instantiated with read_write_same_addr_p=0.
- Zero-clears the array after reset.
- Arbitrates two write requesters onto the single write port using round-robin.
- Detects read/write same-address collisions, suppresses the RAM read on that port, and forwards the write data one cycle later.
- Sits between the pipeline writeback/operand-read logic and the RAM instance; all RAM ports are driven only by this block.

Parameters:
width_p, 32, data width of RAM and all data ports
els_p, 64, number of RAM entries (≥2)
addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived, not overridden)
zero_init_p, 1, 1 = sweep-clear the RAM after reset; 0 = go straight to RUN

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
w0_v_i  in  1  write requester 0 valid
w0_addr_i  in  addr_width_lp  requester 0 address
w0_data_i  in  width_p  requester 0 data
w0_ready_o  out  1  requester 0 granted this cycle
w1_v_i  in  1  write requester 1 valid
w1_addr_i  in  addr_width_lp  requester 1 address
w1_data_i  in  width_p  requester 1 data
w1_ready_o  out  1  requester 1 granted this cycle
r0_v_i  in  1  read port 0 request
r0_addr_i  in  addr_width_lp  read port 0 address
r0_v_o  out  1  read port 0 data valid (one cycle after request)
r0_data_o  out  width_p  read port 0 data
r1_v_i, r1_addr_i, r1_v_o, r1_data_o: same as port 0, for read port 1
mem_w_v_o  out  1  RAM write enable
mem_w_addr_o  out  addr_width_lp  RAM write address
mem_w_data_o  out  width_p  RAM write data
mem_r0_v_o  out  1  RAM read 0 enable
mem_r0_addr_o  out  addr_width_lp  RAM read 0 address
mem_r0_data_i  in  width_p  RAM read 0 data (sync, one cycle)
mem_r1_v_o, mem_r1_addr_o, mem_r1_data_i: same as RAM read 0, for RAM read 1
init_done_o  out  1  high once in RUN

Behaviour:
States and reset:
- FSM states: INIT, RUN.
- Async reset (reset_n_i low) forces: state = INIT when zero_init_p=1, RUN otherwise; init counter = 0; RR pointer = 0 (requester 0 favoured); r0_v_o = r1_v_o = 0; bypass flags = 0; bypass data = 0; init_done_o = !zero_init_p.
- Asserting reset mid-INIT or mid-RUN aborts all activity. The sweep restarts from address 0 after release.

INIT:
- Each cycle: mem_w_v_o = 1, mem_w_addr_o = counter, mem_w_data_o = 0; counter increments.
- After writing address els_p-1, next state is RUN. init_done_o rises in the first RUN cycle, so INIT lasts exactly els_p cycles.
- w*_ready_o = 0, mem_r*_v_o = 0, r*_v_o = 0. Read requests are dropped, not queued.

RUN write arbitration (combinational grant):
- Only one requester valid: that requester is granted.
- Both valid: grant the requester named by the RR pointer. The pointer then flips to the other requester.
- A grant with only one requester valid sets the pointer to the non-granted requester.
- No request: pointer holds.
- mem_w_* carry the granted request. mem_w_v_o = w0_v_i | w1_v_i.
- ready is asserted only to the granted requester. The request is consumed in the same cycle.
- Address range is not checked: out-of-range addresses are the requester's error.

RUN reads (per port p, independently):
- Collision condition hit_p = rp_v_i & mem_w_v_o & (rp_addr_i == mem_w_addr_o).
- mem_rp_v_o = rp_v_i & ~hit_p. mem_rp_addr_o = rp_addr_i.
- Registered next cycle: rp_v_o <= rp_v_i; byp_p <= hit_p; if hit_p, byp_data_p <= mem_w_data_o.
- rp_data_o = byp_p ? byp_data_p : mem_rp_data_i.
- Read latency is 1 cycle. Data reflects the write being issued in the same cycle; write-first semantics are seen by the consumer.
- Both ports may hit the same write simultaneously, and both forward.
- The RAM never sees a same-address read and write in one cycle.
- When rp_v_o = 0, rp_data_o is don't-care.
- No back-pressure on reads. Reads are accepted every RUN cycle.

Test Plan:
- Reset + init, els_p=64, zero_init_p=1: mem_w_v_o high for 64 cycles with addresses 0..63 and data 0. init_done_o rises on cycle 64. A read of addr 5 on cycle 65 returns 0 with r0_v_o=1 one cycle later.
- Round-robin: w0 and w1 both valid for 4 cycles with distinct addresses. Grants go w0, w1, w0, w1. Then only w1 is valid: w1 is granted and the pointer moves to w0.
- Bypass: in RUN, w0 writes 0xDEADBEEF to addr 7 while r0 and r1 both read addr 7 in the same cycle. mem_r0_v_o = mem_r1_v_o = 0. Next cycle both r*_data_o = 0xDEADBEEF with r*_v_o = 1.
- No collision: write 0x11 to addr 3, then a later cycle reads addr 3 on r1 while w1 writes addr 4. mem_r1_v_o = 1, and the following cycle r1_data_o = 0x11 from the RAM.
- Reset mid-INIT: deassert reset, run 20 cycles, then pulse reset_n_i low asynchronously. Outputs drop to reset values immediately. After release, the sweep restarts at addr 0 and completes 64 cycles later.
- zero_init_p=0: init_done_o = 1 out of reset. The first-cycle write from w1 is granted, and a read issued during a would-be INIT cycle is serviced.
